piso_tx_arbiter: RTL and testbench
==================================

# piso_tx_arbiter

Round-robin arbiter and sequencer that shares one parallel-in/serial-out shift register between several parallel-word requesters. It accepts one word at a time through a valid/ready handshake. It loads the word into the internal shift register and shifts it out MSB-first with framing strobes, then inserts a programmable idle gap. It sits between the word-producing blocks and the single serial output path.

## Interface
- WIDTH, 8, bits per word / shift register length (≥2)
- NREQ, 4, number of requesters (≥2)
- GAP_CYCLES, 1, idle cycles inserted after each word (0 allowed)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester word available; held until accepted
- req_data  in  NREQ*WIDTH  packed words, requester i at bits [i*WIDTH +: WIDTH]
- req_ready  out  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
- serial_out  out  1  current serial bit, MSB first
- serial_valid  out  1  serial_out carries a data bit
- frame_start  out  1  high on the first (MSB) bit of each word
- frame_end  out  1  high on the last (LSB) bit of each word
- active_id  out  clog2(NREQ)  index of the requester whose word is being shifted
- busy  out  1  state ≠ IDLE

## Operation
- The FSM has three states: IDLE, SHIFT and GAP.
- IDLE:
  - The grant is the first i with req_valid[i], searching from rr_ptr upward modulo NREQ.
  - req_ready is the combinational one-hot of that grant. It is all-zero if no req_valid is set.
  - On a transfer:
    - load req_data[grant] into the shift register;
    - active_id ← grant;
    - rr_ptr ← (grant+1) mod NREQ;
    - bit_cnt ← WIDTH-1;
    - go to SHIFT.
- SHIFT:
  - serial_out = shreg[WIDTH-1]; serial_valid = 1.
  - Each cycle, shreg shifts left with 0 fill and bit_cnt decrements.
  - When bit_cnt = 0 (last bit):
    - if GAP_CYCLES = 0, go to IDLE;
    - otherwise load gap_cnt ← GAP_CYCLES-1 and go to GAP.
- GAP:
  - serial_valid = 0 and serial_out = 0.
  - gap_cnt decrements. At 0, go to IDLE.
- req_ready is 0 in SHIFT and GAP. Changes on req_valid/req_data outside IDLE have no effect.
- Dropping req_valid without a transfer is legal; the arbiter does not latch requests.
- The pointer advances only on a transfer, so an idle requester never starves others.
- Counters: bit_cnt is clog2(WIDTH) bits and gap_cnt is max(1,clog2(GAP_CYCLES)) bits. Neither counter wraps.

## Timing
- Reset values (async on rst_n low, held while low):
  - state IDLE;
  - rr_ptr 0, shreg 0, bit_cnt 0, gap_cnt 0;
  - serial_out 0, serial_valid 0, frame_start 0, frame_end 0, active_id 0, busy 0;
  - req_ready forced all-zero.
- Latency: serial_valid and frame_start rise on the cycle after the transfer edge.
- serial_valid stays high for exactly WIDTH consecutive cycles.
- frame_end coincides with the WIDTH-th bit.
- GAP_CYCLES low cycles follow. The earliest next transfer is in the first IDLE cycle.
- Throughput: one word per WIDTH + GAP_CYCLES + 1 cycles under continuous requests.
- With WIDTH=8, GAP_CYCLES=1: transfer at cycle T, bits at T+1..T+8, gap at T+9, next transfer at T+10.
- Simultaneous requests: resolved by rr_ptr order in the same cycle. No cycle is lost.
- Reset mid-word: the output aborts immediately; no partial frame_end is emitted. After release, the first transfer is granted from requester 0.
- serial_out, serial_valid, frame_start, frame_end, active_id and busy are registered or decoded from registered state only.

## Structure
- Package piso_pkg holds:
  - state enum (IDLE, SHIFT, GAP);
  - localparam helpers for counter widths.
- Sub-module piso_core (WIDTH param) contains:
  - ports clk, rst_n, load, shift_en, par_in[WIDTH], ser_out;
  - the shift register only.
- The arbiter FSM, counters and round-robin pointer live in piso_tx_arbiter.

## Test plan
- Reset, then a single request: req_valid[2]=1, data 8'hA5.
  - Expect req_ready=4'b0100 for one cycle, active_id=2.
  - serial_out = 1,0,1,0,0,1,0,1, with frame_start on bit 1 and frame_end on bit 8.
  - One gap cycle follows, then busy=0.
- All four requesters valid continuously, data 8'h11/22/44/88.
  - Grant order is 0,1,2,3,0.
  - Words start 10 cycles apart and serial data matches each word.
- Requesters 1 and 3 valid, rr_ptr=2 after a prior grant to 1.
  - Expect 3 granted before 1.
- Change req_data[0] and toggle req_valid during SHIFT.
  - Expect req_ready=0 and no corruption of the in-flight word 8'hF0.
- Assert rst_n=0 during the 4th bit of 8'hCC.
  - Expect all outputs 0 immediately with no frame_end.
  - After release with requester 1 valid, its word is granted and rr_ptr starts at 0.
- GAP_CYCLES=0 build with back-to-back requests from requester 0.
  - Expect serial_valid low for exactly one cycle (the IDLE cycle) between words.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO transmit arbiter slice.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned cnt_width(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_core.sv
// Parallel-load, MSB-first shift register with zero fill.
module piso_core
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] par_in,
  output logic             ser_out
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = par_in;
    end else if (shift_en) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign ser_out = shreg_q[WIDTH-1];

endmodule

// File: rtl/piso_tx_arbiter.sv
// Round-robin arbiter feeding one shared PISO; frames each word and pads an idle gap.
module piso_tx_arbiter
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NREQ       = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     serial_out,
  output logic                     serial_valid,
  output logic                     frame_start,
  output logic                     frame_end,
  output logic [$clog2(NREQ)-1:0]  active_id,
  output logic                     busy
);

  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned BCW = cnt_width(WIDTH);
  localparam int unsigned GCW = cnt_width(GAP_CYCLES);

  state_e           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GCW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [IDW-1:0]   active_id_q, active_id_d;
  logic             serial_valid_q, serial_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_end_q, frame_end_d;
  logic             busy_q, busy_d;

  logic [IDW-1:0]   grant;
  logic             found;
  int unsigned      idx;
  logic             transfer;
  logic [WIDTH-1:0] load_word;
  logic             ser_bit;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 32'(rr_ptr_q) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        grant = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && found) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign transfer  = |(req_valid & req_ready);
  assign load_word = req_data[32'(grant)*WIDTH +: WIDTH];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    active_id_d = active_id_q;
    unique case (state_q)
      IDLE: begin
        if (transfer) begin
          active_id_d = grant;
          rr_ptr_d    = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
          bit_cnt_d   = BCW'(WIDTH - 1);
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == '0) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            gap_cnt_d = GCW'(GAP_CYCLES - 1);
            state_d   = GAP;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Framing flags are precomputed from next state so they leave flops.
    serial_valid_d = (state_d == SHIFT);
    frame_start_d  = transfer;
    frame_end_d    = (state_d == SHIFT) && (bit_cnt_d == '0);
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      bit_cnt_q      <= '0;
      gap_cnt_q      <= '0;
      active_id_q    <= '0;
      serial_valid_q <= 1'b0;
      frame_start_q  <= 1'b0;
      frame_end_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      bit_cnt_q      <= bit_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      active_id_q    <= active_id_d;
      serial_valid_q <= serial_valid_d;
      frame_start_q  <= frame_start_d;
      frame_end_q    <= frame_end_d;
      busy_q         <= busy_d;
    end
  end

  piso_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (transfer),
    .shift_en (state_q == SHIFT),
    .par_in   (load_word),
    .ser_out  (ser_bit)
  );

  assign serial_out   = ser_bit & serial_valid_q;
  assign serial_valid = serial_valid_q;
  assign frame_start  = frame_start_q;
  assign frame_end    = frame_end_q;
  assign active_id    = active_id_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_piso_tx_arbiter.sv
// Directed bench for piso_tx_arbiter: default build plus a zero-gap build.
module tb_piso_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        serial_out, serial_valid, frame_start, frame_end, busy;
  logic [1:0]  active_id;

  logic [3:0]  req_valid0;
  logic [31:0] req_data0;
  logic [3:0]  req_ready0;
  logic        serial_out0, serial_valid0, frame_start0, frame_end0, busy0;
  logic [1:0]  active_id0;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned cyc    = 0;

  piso_tx_arbiter #(.WIDTH(8), .NREQ(4), .GAP_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .serial_out(serial_out), .serial_valid(serial_valid),
    .frame_start(frame_start), .frame_end(frame_end), .active_id(active_id), .busy(busy)
  );

  piso_tx_arbiter #(.WIDTH(8), .NREQ(4), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_data(req_data0),
    .req_ready(req_ready0), .serial_out(serial_out0), .serial_valid(serial_valid0),
    .frame_start(frame_start0), .frame_end(frame_end0), .active_id(active_id0), .busy(busy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called on the first bit cycle; returns on the gap cycle.
  task automatic expect_word(input string tag, input logic [1:0] id, input logic [7:0] w,
                             input bit disturb);
    check({tag, "_id"}, 32'(active_id), 32'(id));
    for (int k = 0; k < 8; k++) begin
      check({tag, "_bit"}, {serial_valid, serial_out, frame_start, frame_end},
            {1'b1, w[7-k], (k == 0), (k == 7)});
      if (disturb) begin
        req_valid     = ~req_valid;
        req_data[7:0] = req_data[7:0] ^ 8'h5B;
        #1;
        check({tag, "_rdy_shift"}, 32'(req_ready), 32'd0);
      end
      tick();
    end
  endtask

  task automatic expect_gap(input string tag);
    check({tag, "_gap"}, {busy, serial_valid, serial_out, frame_start, frame_end, req_ready},
          {5'b10000, 4'b0000});
  endtask

  initial begin
    int unsigned prev_start;
    logic [1:0]  id;
    logic [7:0]  w;
    logic [7:0]  w6;

    rst_n      = 1'b0;
    req_valid  = 4'b1111;
    req_data   = '0;
    req_valid0 = 4'b0000;
    req_data0  = '0;
    prev_start = 0;

    // Reset state, with requests present to show req_ready is held off
    tick();
    tick();
    check("rst_out", {busy, serial_valid, serial_out, frame_start, frame_end}, 5'b0);
    check("rst_id", 32'(active_id), 32'd0);
    check("rst_rdy", 32'(req_ready), 32'd0);

    // Single request from requester 2
    rst_n           = 1'b1;
    req_valid       = 4'b0100;
    req_data[23:16] = 8'hA5;
    #1;
    check("t1_rdy", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    expect_word("t1", 2'd2, 8'hA5, 1'b0);
    expect_gap("t1");
    tick();
    check("t1_idle_busy", 32'(busy), 32'd0);

    // Continuous requests from all four after a fresh reset
    rst_n = 1'b0;
    #2;
    rst_n     = 1'b1;
    req_data  = {8'h88, 8'h44, 8'h22, 8'h11};
    req_valid = 4'b1111;
    #1;
    for (int n = 0; n < 5; n++) begin
      id = 2'(n % 4);
      w  = 8'h11 << id;
      check("t2_rdy", 32'(req_ready), 32'd1 << id);
      tick();
      if (n > 0) check("t2_spacing", cyc - prev_start, 32'd10);
      prev_start = cyc;
      expect_word("t2", id, w, 1'b0);
      expect_gap("t2");
      if (n == 4) req_valid = 4'b0000;
      tick();
    end

    // rr_ptr is 1: grant 1, then with 1 and 3 waiting, 3 wins before 1
    req_data[15:8] = 8'h5A;
    req_valid      = 4'b0010;
    #1;
    check("t3_rdy_a", 32'(req_ready), 32'b0010);
    tick();
    req_valid       = 4'b1010;
    req_data[31:24] = 8'h96;
    expect_word("t3a", 2'd1, 8'h5A, 1'b0);
    expect_gap("t3a");
    tick();
    check("t3_rdy_b", 32'(req_ready), 32'b1000);
    tick();
    expect_word("t3b", 2'd3, 8'h96, 1'b0);
    expect_gap("t3b");
    tick();
    check("t3_rdy_c", 32'(req_ready), 32'b0010);
    tick();
    expect_word("t3c", 2'd1, 8'h5A, 1'b0);
    expect_gap("t3c");
    req_valid = 4'b0000;
    tick();

    // Inputs disturbed while 8'hF0 is in flight
    req_data[7:0] = 8'hF0;
    req_valid     = 4'b0001;
    #1;
    check("t4_rdy", 32'(req_ready), 32'b0001);
    tick();
    expect_word("t4", 2'd0, 8'hF0, 1'b1);
    expect_gap("t4");
    req_valid = 4'b0000;
    tick();

    // Reset during the 4th bit of 8'hCC
    req_data[23:16] = 8'hCC;
    req_valid       = 4'b0100;
    #1;
    check("t5_rdy", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      check("t5_pre_bit", {serial_valid, serial_out}, {1'b1, (k < 2)});
      tick();
    end
    check("t5_bit4", {serial_valid, serial_out, frame_end}, 3'b100);
    rst_n     = 1'b0;
    req_valid = 4'b1010;
    #1;
    check("t5_abort", {busy, serial_valid, serial_out, frame_start, frame_end}, 5'b0);
    check("t5_abort_id", 32'(active_id), 32'd0);
    check("t5_abort_rdy", 32'(req_ready), 32'd0);
    tick();
    check("t5_hold", {busy, serial_valid, frame_end}, 3'b0);
    rst_n           = 1'b1;
    req_data[15:8]  = 8'h3C;
    req_data[31:24] = 8'h77;
    #1;
    check("t5_rdy_post", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    expect_word("t5", 2'd1, 8'h3C, 1'b0);
    expect_gap("t5");
    tick();

    // Zero-gap build: back-to-back words from requester 0
    req_valid0 = 4'b0001;
    for (int n = 0; n < 3; n++) begin
      w6 = (n == 0) ? 8'h81 : (n == 1) ? 8'h7E : 8'hC3;
      req_data0[7:0] = w6;
      #1;
      check("t6_rdy", 32'(req_ready0), 32'b0001);
      check("t6_idle_low", 32'(serial_valid0), 32'd0);
      tick();
      check("t6_id", 32'(active_id0), 32'd0);
      for (int k = 0; k < 8; k++) begin
        check("t6_bit", {serial_valid0, serial_out0, frame_start0, frame_end0},
              {1'b1, w6[7-k], (k == 0), (k == 7)});
        tick();
      end
    end
    req_valid0 = 4'b0000;
    check("t6_end", {serial_valid0, busy0}, 2'b00);
    tick();
    check("t6_stay_idle", {serial_valid0, busy0}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
